ray_plane_hit: RTL and testbench
================================

Name: ray_plane_hit

Overview:
- Stage directly upstream of the triangle inside/outside test. It consumes one ray/triangle job from an input FIFO and computes the ray–plane intersection parameter `t = dot(n, v0-o) / dot(n, d)`.
- It then forms `p_hit = o + t*d` and writes `p_hit`, `t`, `normal` and a miss flag to an output FIFO.
- All arithmetic is signed 32-bit fixed point with `Q_BITS` fraction bits.
- Division is iterative (multi-cycle), so the block processes one job at a time under an FSM.

Parameters:
- `Q_BITS`, 10, number of fractional bits in every fixed-point value.
- `DIV_ITERS`, 64, restoring-divider iterations; equals the dividend width.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `in_origin`  in  96  ray origin o; x=[31:0], y=[63:32], z=[95:64], signed Q
- `in_dir`  in  96  ray direction d, same packing
- `in_v0`  in  96  triangle vertex v0, same packing
- `in_normal`  in  96  triangle normal n, same packing
- `fifo_in_empty`  in  1  input FIFO empty (first-word-fall-through; data valid when low)
- `fifo_out_full`  in  1  output FIFO full
- `fifo_in_rd_en`  out  1  pop input FIFO
- `fifo_out_wr_en`  out  1  push output FIFO
- `p_hit`  out  96  intersection point, same packing
- `t_out`  out  32  signed Q ray parameter
- `normal_out`  out  96  registered copy of `in_normal`, forwarded for the inside test
- `miss`  out  1  1 = no valid forward hit

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset values: all registered outputs 0, FSM in IDLE. `fifo_in_rd_en` and `fifo_out_wr_en` are 0 during reset.
- FSM states: IDLE, DOT, DIV, MUL, WRITE.
- IDLE:
  - `fifo_in_rd_en = !fifo_in_empty` (combinational).
  - On the same edge the block captures o, d, v0, n and moves to DOT.
  - Nothing is popped while the FSM is outside IDLE.
- DOT (1 cycle):
  - `e = v0 - o` per component, 32-bit wrap.
  - `num = (sum of n_i*e_i, 64-bit) >>> Q_BITS`, truncated to 32 bits.
  - `den = (sum of n_i*d_i) >>> Q_BITS`, truncated to 32 bits.
  - If `den == 0`: set miss=1, `t_out=0`, `p_hit=0`, go to WRITE.
  - Otherwise load the divider and go to DIV.
- DIV (exactly `DIV_ITERS` cycles):
  - Restoring division of `|num| << Q_BITS` (64-bit) by `|den|`.
  - Quotient sign = `sign(num) XOR sign(den)`.
  - Magnitude > 0x7FFFFFFF saturates to 0x7FFFFFFF before the sign is applied.
  - Then go to MUL.
- MUL (1 cycle):
  - `p_i = o_i + ((t*d_i) 64-bit >>> Q_BITS)`, truncated to 32 bits.
  - `miss = (t <= 0)`. `p_hit` is still computed on a miss.
  - Register `p_hit`, `t_out`, `miss`, `normal_out`; go to WRITE.
- WRITE:
  - `fifo_out_wr_en = !fifo_out_full` (combinational).
  - When asserted, go to IDLE on that edge.
  - Outputs are held stable while `fifo_out_full` is high.
- Latency, with the `rd_en` cycle as cycle 0:
  - Normal path: `wr_en` at cycle 3+`DIV_ITERS` (67 with defaults) if the output FIFO is not full.
  - `den==0` path: `wr_en` at cycle 2.
- Throughput: the next `rd_en` occurs no earlier than the cycle after `wr_en`. There is no overlap between jobs.
- Reset mid-operation: the in-flight job is discarded, outputs are zeroed, and no `wr_en` is issued.
- Output registers keep their last value in IDLE.

Decomposition:
- Shared package `rt_pkg`:
  - `Q_BITS` constant
  - `vec3_t` typedef (int [2:0])
  - `pack_vec3` / `unpack_vec3` functions for the 96-bit packing
  - fixed-point `ONE` = 1<<Q_BITS
- FSM state enum stays local to the module.
- Sub-module `sdiv_iter`:
  - restoring unsigned divider
  - `start`/`busy`/`done` handshake
  - `DIV_ITERS` parameter, 64-bit dividend, 32-bit divisor
  - sign handling and saturation done in `ray_plane_hit`

Test Plan:
- Axial hit: o=(0,0,0), d=(0,0,1024), v0=(0,0,5120), n=(0,0,1024) -> `rd_en` cycle 0; `wr_en` cycle 67; `t_out`=5120; `p_hit`=(0,0,5120); miss=0; `normal_out`=(0,0,1024).
- Parallel ray: same but d=(1024,0,0) -> den=0; `wr_en` at cycle 2; miss=1; `t_out`=0; `p_hit`=(0,0,0).
- Behind origin: v0=(0,0,-5120), rest as axial -> `t_out`=-5120; miss=1; `p_hit`=(0,0,-5120).
- Backpressure: axial job with `fifo_out_full` high cycles 60–80 -> `wr_en` first at cycle 81; outputs stable cycles 67–81; no `rd_en` before cycle 82.
- Back-to-back: two jobs queued (axial, then v0 z=2048) -> second `rd_en` at cycle 68, exactly one cycle after the first `wr_en`; second `t_out`=2048.
- Reset mid-DIV: assert reset at cycle 30 for 2 cycles with the job queued -> all outputs 0, no `wr_en`; after release, IDLE re-pops when `fifo_in_empty`=0.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared fixed-point types and helpers for the ray-tracing pipeline stages.
// Vectors travel between stages as 96-bit words: x=[31:0], y=[63:32], z=[95:64].
package rt_pkg;

    localparam int Q_BITS = 10;
    localparam int ONE    = 1 << Q_BITS;

    typedef int vec3_t [2:0];

    function automatic logic [95:0] pack_vec3(input vec3_t v);
        return {v[2], v[1], v[0]};
    endfunction

    function automatic vec3_t unpack_vec3(input logic [95:0] bits);
        vec3_t v;
        v[0] = bits[31:0];
        v[1] = bits[63:32];
        v[2] = bits[95:64];
        return v;
    endfunction

endpackage

// File: rtl/sdiv_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done is high during the final iteration, so the quotient is valid right after that edge.
module sdiv_iter #(
    parameter int DIV_ITERS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] quotient
);

    localparam int CW = $clog2(DIV_ITERS);

    logic [63:0]   quo_reg;
    logic [31:0]   rem_reg;
    logic [31:0]   div_reg;
    logic [CW-1:0] count_reg;
    logic          busy_reg;

    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;
    logic        unused_diff_msb;

    // The remainder stays below the divisor, so the trial value needs only 33 bits.
    assign trial = {rem_reg, quo_reg[63]};
    assign diff  = trial - {1'b0, div_reg};
    assign fits  = (trial >= {1'b0, div_reg});
    assign unused_diff_msb = diff[32];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quo_reg   <= '0;
            rem_reg   <= '0;
            div_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            quo_reg   <= dividend;
            rem_reg   <= '0;
            div_reg   <= divisor;
            count_reg <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            quo_reg   <= {quo_reg[62:0], fits};
            rem_reg   <= fits ? diff[31:0] : trial[31:0];
            count_reg <= count_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = busy_reg && (count_reg == CW'(DIV_ITERS - 1));
    assign quotient = quo_reg;

endmodule

// File: rtl/ray_plane_hit.sv
// Ray/plane intersection stage: t = dot(n, v0-o) / dot(n, d), p_hit = o + t*d.
// One job at a time; the iterative divider sets the latency of the non-degenerate path.
module ray_plane_hit #(
    parameter int Q_BITS    = rt_pkg::Q_BITS,
    parameter int DIV_ITERS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [95:0] in_origin,
    input  logic [95:0] in_dir,
    input  logic [95:0] in_v0,
    input  logic [95:0] in_normal,
    input  logic        fifo_in_empty,
    input  logic        fifo_out_full,
    output logic        fifo_in_rd_en,
    output logic        fifo_out_wr_en,
    output logic [95:0] p_hit,
    output logic [31:0] t_out,
    output logic [95:0] normal_out,
    output logic        miss
);

    import rt_pkg::*;

    typedef enum logic [2:0] {IDLE, DOT, DIV, MUL, WRITE} state_t;

    state_t state_reg;

    vec3_t o_reg;
    vec3_t d_reg;
    vec3_t v0_reg;
    vec3_t n_reg;
    logic  neg_reg;

    vec3_t p_reg;
    vec3_t normal_reg;
    int    t_reg;
    logic  miss_reg;

    int                 e_v      [3];
    logic signed [63:0] num_term [3];
    logic signed [63:0] den_term [3];
    logic signed [63:0] mul_term [3];
    vec3_t              p_calc;

    logic signed [63:0] num_sum;
    logic signed [63:0] den_sum;
    logic [31:0]        num;
    logic [31:0]        den;
    logic [31:0]        abs_num;
    logic [31:0]        abs_den;
    logic [63:0]        dividend;
    logic [31:0]        q_mag;
    logic signed [31:0] t_calc;

    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [63:0] quotient;
    logic        unused_bits;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comp
            logic unused_mul;

            assign e_v[gi]      = v0_reg[gi] - o_reg[gi];
            assign num_term[gi] = longint'(n_reg[gi]) * longint'(e_v[gi]);
            assign den_term[gi] = longint'(n_reg[gi]) * longint'(d_reg[gi]);
            assign mul_term[gi] = longint'(t_calc) * longint'(d_reg[gi]);
            assign p_calc[gi]   = o_reg[gi] + int'(mul_term[gi][Q_BITS+31:Q_BITS]);
            assign unused_mul   = ^{mul_term[gi][63:Q_BITS+32], mul_term[gi][Q_BITS-1:0]};
        end
    endgenerate

    // Slicing [Q_BITS+31:Q_BITS] is the arithmetic shift followed by 32-bit truncation.
    assign num_sum = num_term[0] + num_term[1] + num_term[2];
    assign den_sum = den_term[0] + den_term[1] + den_term[2];
    assign num     = num_sum[Q_BITS+31:Q_BITS];
    assign den     = den_sum[Q_BITS+31:Q_BITS];

    assign abs_num  = num[31] ? -num : num;
    assign abs_den  = den[31] ? -den : den;
    assign dividend = {32'd0, abs_num} << Q_BITS;

    assign div_start = (state_reg == DOT) && (den != 32'd0);

    sdiv_iter #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (abs_den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    // Saturate the magnitude first so negation can never overflow.
    assign q_mag  = (|quotient[63:31]) ? 32'h7FFF_FFFF : quotient[31:0];
    assign t_calc = neg_reg ? -q_mag : q_mag;

    assign unused_bits = ^{num_sum[63:Q_BITS+32], num_sum[Q_BITS-1:0],
                           den_sum[63:Q_BITS+32], den_sum[Q_BITS-1:0], div_busy};

    assign fifo_in_rd_en  = !reset && (state_reg == IDLE)  && !fifo_in_empty;
    assign fifo_out_wr_en = !reset && (state_reg == WRITE) && !fifo_out_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            o_reg      <= '{default: 0};
            d_reg      <= '{default: 0};
            v0_reg     <= '{default: 0};
            n_reg      <= '{default: 0};
            neg_reg    <= 1'b0;
            p_reg      <= '{default: 0};
            normal_reg <= '{default: 0};
            t_reg      <= 0;
            miss_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fifo_in_rd_en) begin
                        o_reg     <= unpack_vec3(in_origin);
                        d_reg     <= unpack_vec3(in_dir);
                        v0_reg    <= unpack_vec3(in_v0);
                        n_reg     <= unpack_vec3(in_normal);
                        state_reg <= DOT;
                    end
                end
                DOT: begin
                    if (den == 32'd0) begin
                        // Ray parallel to the plane: report a miss without dividing.
                        miss_reg   <= 1'b1;
                        t_reg      <= 0;
                        p_reg      <= '{default: 0};
                        normal_reg <= n_reg;
                        state_reg  <= WRITE;
                    end else begin
                        neg_reg   <= num[31] ^ den[31];
                        state_reg <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state_reg <= MUL;
                    end
                end
                MUL: begin
                    p_reg      <= p_calc;
                    t_reg      <= t_calc;
                    miss_reg   <= t_calc[31] || (t_calc == 32'sd0);
                    normal_reg <= n_reg;
                    state_reg  <= WRITE;
                end
                WRITE: begin
                    if (fifo_out_wr_en) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign p_hit      = pack_vec3(p_reg);
    assign normal_out = pack_vec3(normal_reg);
    assign t_out      = t_reg;
    assign miss       = miss_reg;

endmodule

// File: tb/tb_ray_plane_hit.sv
// Directed bench for ray_plane_hit: FIFO model feeding jobs, scoreboard of expected results
// computed from the fixed-point formulas, latency/backpressure/reset checks.
module tb_ray_plane_hit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [95:0] in_origin = '0;
    logic [95:0] in_dir = '0;
    logic [95:0] in_v0 = '0;
    logic [95:0] in_normal = '0;
    logic        fifo_in_empty = 1'b1;
    logic        fifo_out_full = 1'b0;
    logic        fifo_in_rd_en;
    logic        fifo_out_wr_en;
    logic [95:0] p_hit;
    logic [31:0] t_out;
    logic [95:0] normal_out;
    logic        miss;

    always #5 clock = ~clock;

    ray_plane_hit dut (
        .clock          (clock),
        .reset          (reset),
        .in_origin      (in_origin),
        .in_dir         (in_dir),
        .in_v0          (in_v0),
        .in_normal      (in_normal),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_full  (fifo_out_full),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_out_wr_en (fifo_out_wr_en),
        .p_hit          (p_hit),
        .t_out          (t_out),
        .normal_out     (normal_out),
        .miss           (miss)
    );

    typedef struct {
        logic [95:0] o;
        logic [95:0] d;
        logic [95:0] v0;
        logic [95:0] n;
    } job_t;

    typedef struct {
        logic [95:0] p;
        logic [95:0] n;
        logic [31:0] t;
        logic        miss;
        int          lat;
    } exp_t;

    job_t jobs[$];
    exp_t exps[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rd_cyc     = 0;
    int last_wr    = -1000;
    int last_gap   = 0;
    int reset_left = 3;
    int bp_lo      = 1 << 30;
    int bp_hi      = 1 << 30;
    bit inflight   = 1'b0;
    bit bp_armed   = 1'b0;

    function automatic logic [95:0] v3(input int x, input int y, input int z);
        return {z, y, x};
    endfunction

    function automatic int comp(input logic [95:0] v, input int i);
        logic [31:0] w;
        w = v[i*32 +: 32];
        return int'(w);
    endfunction

    function automatic int fx(input longint v);
        longint s;
        s = v >>> 10;
        return int'(s);
    endfunction

    function automatic exp_t model(input job_t j);
        longint ns = 0;
        longint ds = 0;
        longint an, ad, mag;
        int     num, den, t, pi;
        exp_t   e;
        for (int i = 0; i < 3; i++) begin
            ns += longint'(comp(j.n, i)) * longint'(comp(j.v0, i) - comp(j.o, i));
            ds += longint'(comp(j.n, i)) * longint'(comp(j.d, i));
        end
        num = fx(ns);
        den = fx(ds);
        e.n = j.n;
        if (den == 0) begin
            e.p = '0; e.t = '0; e.miss = 1'b1; e.lat = 2;
        end else begin
            an  = (num < 0) ? -longint'(num) : longint'(num);
            ad  = (den < 0) ? -longint'(den) : longint'(den);
            mag = (an << 10) / ad;
            if (mag > 64'sh7FFF_FFFF) mag = 64'sh7FFF_FFFF;
            t = ((num < 0) != (den < 0)) ? -int'(mag) : int'(mag);
            e.t = t;
            e.miss = (t <= 0);
            for (int i = 0; i < 3; i++) begin
                pi = comp(j.o, i) + fx(longint'(t) * longint'(comp(j.d, i)));
                e.p[i*32 +: 32] = pi;
            end
            e.lat = 67;
        end
        return e;
    endfunction

    task automatic push_job(input logic [95:0] o, input logic [95:0] d,
                            input logic [95:0] v0, input logic [95:0] n);
        job_t j;
        j.o = o; j.d = d; j.v0 = v0; j.n = n;
        jobs.push_back(j);
        exps.push_back(model(j));
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive the FIFO model after the edge, observe the DUT at the falling edge.
    task automatic cycle();
        exp_t e;
        int   exp_wr;
        @(posedge clock);
        cyc++;
        #1;
        reset = (reset_left > 0);
        if (reset_left > 0) reset_left--;
        fifo_in_empty = (jobs.size() == 0);
        if (jobs.size() > 0) begin
            in_origin = jobs[0].o;
            in_dir    = jobs[0].d;
            in_v0     = jobs[0].v0;
            in_normal = jobs[0].n;
        end
        fifo_out_full = (cyc >= bp_lo) && (cyc <= bp_hi);
        @(negedge clock);
        if (reset) begin
            chk("reset_outs", {p_hit, t_out, normal_out, miss}, '0);
            chk("reset_strobes", {fifo_in_rd_en, fifo_out_wr_en}, '0);
            if (inflight) begin
                void'(exps.pop_front());
                inflight = 1'b0;
            end
        end else begin
            if (fifo_in_rd_en) begin
                chk("no_overlap", inflight, 0);
                last_gap = cyc - last_wr;
                rd_cyc   = cyc;
                inflight = 1'b1;
                if (jobs.size() > 0) void'(jobs.pop_front());
                if (bp_armed) begin
                    bp_lo = cyc + 60;
                    bp_hi = cyc + 80;
                    bp_armed = 1'b0;
                end
            end
            if (fifo_out_wr_en) begin
                chk("wr_in_flight", inflight, 1);
                if (inflight && exps.size() > 0) begin
                    e = exps.pop_front();
                    exp_wr = rd_cyc + e.lat;
                    if (exp_wr >= bp_lo && exp_wr <= bp_hi) exp_wr = bp_hi + 1;
                    chk("latency", cyc - rd_cyc, exp_wr - rd_cyc);
                    chk("t_out", t_out, e.t);
                    chk("p_hit", p_hit, e.p);
                    chk("normal_out", normal_out, e.n);
                    chk("miss", miss, e.miss);
                    $display("job rd@%0d wr@%0d t=%0d miss=%0b p=%h", rd_cyc, cyc,
                             $signed(t_out), miss, p_hit);
                end
                inflight = 1'b0;
                last_wr  = cyc;
            end else if (inflight && exps.size() > 0 && cyc >= rd_cyc + exps[0].lat
                         && cyc <= bp_hi) begin
                chk("hold_t", t_out, exps[0].t);
                chk("hold_p", p_hit, exps[0].p);
            end
        end
    endtask

    task automatic run(input int maxc);
        int n = 0;
        while ((jobs.size() > 0 || inflight || reset_left > 0) && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (jobs.size() == 0 && !inflight), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset with nothing queued, then an idle cycle.
        run(10);
        cycle();
        chk("idle_outs", {p_hit, t_out, normal_out, miss, fifo_out_wr_en}, '0);

        // Axial hit, parallel ray, hit behind the origin.
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, 5120), v3(0, 0, 1024));
        run(200);
        push_job(v3(0, 0, 0), v3(1024, 0, 0), v3(0, 0, 5120), v3(0, 0, 1024));
        run(200);
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, -5120), v3(0, 0, 1024));
        run(200);

        // Negative denominator, saturating quotient, and a few mixed vectors.
        push_job(v3(0, 0, 0), v3(0, 0, -1024), v3(0, 0, -5120), v3(0, 0, 1024));
        push_job(v3(0, 0, 0), v3(1, 0, 0), v3(1 << 30, 0, 0), v3(1024, 0, 0));
        for (int k = 0; k < 3; k++) begin
            push_job(v3($urandom_range(0, 8191) - 4096, $urandom_range(0, 8191) - 4096, 300),
                     v3($urandom_range(0, 2047) - 1024, 512, $urandom_range(0, 2047) - 1024),
                     v3($urandom_range(0, 8191) - 4096, -700, $urandom_range(0, 8191) - 4096),
                     v3(300, $urandom_range(0, 2047) - 1024, 1024));
        end
        run(800);

        // Output FIFO full for cycles 60..80 after the pop.
        bp_armed = 1'b1;
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, 5120), v3(0, 0, 1024));
        run(300);

        // Back-to-back jobs: second pop exactly one cycle after the first push.
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, 5120), v3(0, 0, 1024));
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, 2048), v3(0, 0, 1024));
        run(400);
        chk("b2b_gap", last_gap, 1);

        // Reset during the divide: the first job is dropped, the queued one runs after release.
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, 5120), v3(0, 0, 1024));
        push_job(v3(0, 0, 0), v3(0, 0, 1024), v3(0, 0, 2048), v3(0, 0, 1024));
        n = 0;
        while (!inflight && n < 20) begin
            cycle();
            n++;
        end
        while (cyc < rd_cyc + 29) cycle();
        reset_left = 2;
        run(400);
        chk("scoreboard_empty", exps.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
